// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared state encoding and default timing constants for lock supervision
package clk_rst_pkg;
  typedef enum logic [2:0] {MMCM_RST, WAIT_LOCK, HOLD, RUN, FAIL} lockSeqState_t;
  localparam int DEF_NUM_LOCKS = 2;
  localparam int DEF_LOCK_HOLD_CYCLES = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int DEF_MMCM_RST_CYCLES = 16;
  localparam int DEF_MAX_RETRIES = 3;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] qOut
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clkIn or posedge rstIn)
    if (rstIn) begin
      meta <= '0;
      qOut <= '0;
    end else begin
      meta <= dIn;
      qOut <= meta;
    end
endmodule

// File: rtl/lock_rst_seq.sv
// lock_rst_seq: MMCM reset/lock supervisor that releases fabric reset after stable lock
module lock_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int NUM_LOCKS           = DEF_NUM_LOCKS,
  parameter int LOCK_HOLD_CYCLES    = DEF_LOCK_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MMCM_RST_CYCLES     = DEF_MMCM_RST_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               clkIn,
  input  logic                               rstIn,
  input  logic [NUM_LOCKS-1:0]               lockedIn,
  output logic                               mmcmRstOut,
  output logic                               rstLclOut,
  output logic                               allLockedOut,
  output logic                               lockLossOut,
  output logic                               failOut,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retryCntOut
);
  localparam int CNT_A   = LOCK_TIMEOUT_CYCLES > LOCK_HOLD_CYCLES ? LOCK_TIMEOUT_CYCLES : LOCK_HOLD_CYCLES;
  localparam int CNT_MAX = CNT_A > MMCM_RST_CYCLES ? CNT_A : MMCM_RST_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);
  lockSeqState_t state, stateNext;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retryNext;
  logic [NUM_LOCKS-1:0] lockedSync;
  logic allLocked, canRetry;
  sync_2ff #(.WIDTH(NUM_LOCKS)) uSync (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .dIn   (lockedIn),
    .qOut  (lockedSync)
  );
  assign allLocked = &lockedSync;
  assign canRetry  = retryCntOut < RW'(MAX_RETRIES);
  // all-locked is tested before the timeout so a lock arriving on the last wait cycle still counts
  always_comb begin
    stateNext = state;
    retryNext = retryCntOut;
    case (state)
      MMCM_RST: stateNext = (cnt == CW'(MMCM_RST_CYCLES - 1)) ? WAIT_LOCK : MMCM_RST;
      WAIT_LOCK:
        if (allLocked) stateNext = HOLD;
        else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          stateNext = canRetry ? MMCM_RST : FAIL;
          retryNext = canRetry ? retryCntOut + 1'b1 : retryCntOut;
        end
      HOLD:
        if (!allLocked) stateNext = WAIT_LOCK;
        else if (cnt == CW'(LOCK_HOLD_CYCLES - 1)) begin
          stateNext = RUN;
          retryNext = '0;
        end
      RUN: stateNext = allLocked ? RUN : MMCM_RST;
      default: stateNext = FAIL;
    endcase
  end
  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clkIn or posedge rstIn)
    if (rstIn) begin
      state        <= MMCM_RST;
      cnt          <= '0;
      mmcmRstOut   <= 1'b1;
      rstLclOut    <= 1'b1;
      allLockedOut <= 1'b0;
      lockLossOut  <= 1'b0;
      failOut      <= 1'b0;
      retryCntOut  <= '0;
    end else begin
      state        <= stateNext;
      cnt          <= (stateNext == state) ? cnt + 1'b1 : '0;
      mmcmRstOut   <= stateNext == MMCM_RST;
      rstLclOut    <= stateNext != RUN;
      allLockedOut <= stateNext == RUN;
      failOut      <= stateNext == FAIL;
      lockLossOut  <= lockLossOut | (state == RUN && !allLocked);
      retryCntOut  <= retryNext;
    end
endmodule

// File: tb/tb_lock_rst_seq.sv
// tb_lock_rst_seq: randomized check of lock_rst_seq against a phase/elapsed-time reference model
module tb_lock_rst_seq;
  localparam int HOLD_N = 8;
  localparam int TO_N   = 64;
  localparam int RST_N  = 4;
  localparam int MAX_R  = 2;
  localparam int P_RST = 0, P_WAIT = 1, P_HOLD = 2, P_RUN = 3, P_FAIL = 4;
  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  logic [1:0] lockedIn = 2'b00;
  logic mmcmRstOut, rstLclOut, allLockedOut, lockLossOut, failOut;
  logic [1:0] retryCntOut;
  int nChecks = 0;
  int nPass = 0;
  int phase, inPhase, retries;
  bit loss;
  logic [1:0] hist[$];

  always #5 clkIn = ~clkIn;

  lock_rst_seq #(
    .NUM_LOCKS(2), .LOCK_HOLD_CYCLES(HOLD_N), .LOCK_TIMEOUT_CYCLES(TO_N),
    .MMCM_RST_CYCLES(RST_N), .MAX_RETRIES(MAX_R)
  ) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .lockedIn     (lockedIn),
    .mmcmRstOut   (mmcmRstOut),
    .rstLclOut    (rstLclOut),
    .allLockedOut (allLockedOut),
    .lockLossOut  (lockLossOut),
    .failOut      (failOut),
    .retryCntOut  (retryCntOut)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic enter(input int p);
    phase   = p;
    inPhase = 0;
  endtask

  task automatic modelReset();
    enter(P_RST);
    retries = 0;
    loss    = 1'b0;
    hist    = '{2'b00, 2'b00};
  endtask

  // decisions see the lock inputs as they were two edges earlier
  task automatic modelEdge();
    bit ok;
    if (rstIn) return;
    ok = (hist.pop_front() == 2'b11);
    hist.push_back(lockedIn);
    inPhase++;
    case (phase)
      P_RST: if (inPhase == RST_N) enter(P_WAIT);
      P_WAIT:
        if (ok) enter(P_HOLD);
        else if (inPhase == TO_N) begin
          if (retries < MAX_R) begin
            retries++;
            enter(P_RST);
          end else enter(P_FAIL);
        end
      P_HOLD:
        if (!ok) enter(P_WAIT);
        else if (inPhase == HOLD_N) begin
          retries = 0;
          enter(P_RUN);
        end
      P_RUN:
        if (!ok) begin
          loss = 1'b1;
          enter(P_RST);
        end
      default: ;
    endcase
  endtask

  task automatic checkAll(input string ctx);
    chk({ctx, ".mmcmRst"}, mmcmRstOut, phase == P_RST);
    chk({ctx, ".rstLcl"}, rstLclOut, phase != P_RUN);
    chk({ctx, ".allLocked"}, allLockedOut, phase == P_RUN);
    chk({ctx, ".fail"}, failOut, phase == P_FAIL);
    chk({ctx, ".lockLoss"}, lockLossOut, loss);
    chk({ctx, ".retryCnt"}, retryCntOut, retries);
  endtask

  task automatic step(input string ctx);
    @(posedge clkIn);
    modelEdge();
    @(negedge clkIn);
    checkAll(ctx);
  endtask

  task automatic runLk(input string ctx, input int n, input logic [1:0] lk);
    lockedIn = lk;
    repeat (n) step(ctx);
  endtask

  task automatic applyReset(input int n);
    rstIn = 1'b1;
    modelReset();
    #1;
    checkAll("rstAsync");
    repeat (n) step("rstHeld");
    rstIn = 1'b0;
  endtask

  initial begin
    #2;
    applyReset(2);
    runLk("nominal", 10, 2'b00);
    runLk("nominal", 30, 2'b11);
    chk("nominal.inRun", allLockedOut, 1);
    chk("nominal.rstReleased", rstLclOut, 0);

    runLk("lossRun", $urandom_range(1, 4), 2'b10);
    runLk("lossRun", 40, 2'b11);
    chk("lossRun.sticky", lockLossOut, 1);
    chk("lossRun.backInRun", allLockedOut, 1);

    applyReset(2);
    runLk("glitchHold", RST_N + $urandom_range(0, 10), 2'b00);
    runLk("glitchHold", 7, 2'b11);
    runLk("glitchHold", 1, 2'b01);
    runLk("glitchHold", 25, 2'b11);
    chk("glitchHold.inRun", allLockedOut, 1);

    applyReset(2);
    runLk("midHold", 6, 2'b00);
    runLk("midHold", 2 + $urandom_range(1, 6), 2'b11);
    applyReset(3);
    runLk("afterHoldRst", 10, 2'b00);
    runLk("afterHoldRst", 30, 2'b11);
    chk("afterHoldRst.inRun", allLockedOut, 1);
    chk("afterHoldRst.noLoss", lockLossOut, 0);

    applyReset(2);
    runLk("timeout", 3 * (RST_N + TO_N) + 20, 2'b10);
    chk("timeout.fail", failOut, 1);
    chk("timeout.rstLcl", rstLclOut, 1);
    chk("timeout.retries", retryCntOut, MAX_R);
    runLk("failTerminal", 30, 2'b11);
    chk("failTerminal.fail", failOut, 1);
    applyReset(2);
    runLk("afterFailRst", 10, 2'b00);
    runLk("afterFailRst", 30, 2'b11);
    chk("afterFailRst.inRun", allLockedOut, 1);

    // soak: long locked stretches broken by random drops, occasional resets and outages
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] lk;
      lk = lockedIn;
      if (lk == 2'b11) begin
        if ($urandom_range(0, 39) == 0) lk[$urandom_range(0, 1)] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) lk[$urandom_range(0, 1)] = 1'b1;
      if ($urandom_range(0, 599) == 0) lk = 2'b00;
      lockedIn = lk;
      if ($urandom_range(0, 499) == 0) applyReset($urandom_range(1, 3));
      else step("soak");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
